// File: rtl/relu_maxpool_layer.sv
// 2x2 stride-2 max pooling with optional fused ReLU over a raster-ordered D x D map.
// One half-row of partial maxima is kept in a line buffer; nothing else spans a row.
module relu_maxpool_layer #(
    parameter int D          = 220,
    parameter int DATA_WIDTH = 32,
    parameter int RELU_EN    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int HALF = D / 2;
    localparam int CW   = (D > 2) ? $clog2(D) : 1;
    localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int SB   = DATA_WIDTH - 1;

    // Sign-magnitude ordering; on a tie (including +0 vs -0) the earlier operand a is kept.
    function automatic logic [DATA_WIDTH-1:0] fmax(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic b_wins;
        if (a[SB-1:0] == '0 && b[SB-1:0] == '0) begin
            b_wins = 1'b0;
        end else if (a[SB] != b[SB]) begin
            b_wins = ~b[SB];
        end else if (!a[SB]) begin
            b_wins = (b[SB-1:0] > a[SB-1:0]);
        end else begin
            b_wins = (b[SB-1:0] < a[SB-1:0]);
        end
        return b_wins ? b : a;
    endfunction

    logic [CW-1:0]         col_reg, col_next;
    logic [CW-1:0]         row_reg, row_next;
    logic [DATA_WIDTH-1:0] hold_reg, hold_next;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic [DATA_WIDTH-1:0] linebuf [HALF];

    logic                  col_last, row_last;
    logic                  even_row, odd_col;
    logic                  wr_en, emit;
    logic [AW-1:0]         wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] pair_max;
    logic [DATA_WIDTH-1:0] result, relu_result;

    assign col_last = (col_reg == CW'(D - 1));
    assign row_last = (row_reg == CW'(D - 1));
    assign even_row = ~row_reg[0];
    assign odd_col  = col_reg[0];

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (valid_in) begin
            if (col_last) begin
                col_next = '0;
                row_next = row_last ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    // The read address tracks the column the next accepted pixel will land on, so the
    // registered read data is already valid when that pixel arrives, even back-to-back.
    assign rd_addr  = AW'(col_next >> 1);
    assign wr_addr  = AW'(col_reg >> 1);
    assign pair_max = fmax(hold_reg, pxl_in);
    assign wr_en    = valid_in & even_row & odd_col;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            linebuf[wr_addr] <= pair_max;
        end
        // Write-first forwarding covers D=2, where the last write of an even row and the
        // first read of the following odd row hit the same entry on the same edge.
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_reg <= pair_max;
        end else begin
            rd_data_reg <= linebuf[rd_addr];
        end
    end

    always_comb begin
        hold_next = hold_reg;
        if (valid_in && !odd_col) begin
            hold_next = even_row ? pxl_in : fmax(rd_data_reg, pxl_in);
        end
    end

    assign result = pair_max;
    assign emit   = valid_in & ~even_row & odd_col;

    generate
        if (RELU_EN != 0) begin : g_relu
            assign relu_result = result[SB] ? '0 : result;
        end else begin : g_bypass
            assign relu_result = result;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_reg    <= '0;
            row_reg    <= '0;
            hold_reg   <= '0;
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            col_reg    <= col_next;
            row_reg    <= row_next;
            hold_reg   <= hold_next;
            valid_out  <= emit;
            frame_done <= emit & row_last & col_last;
            if (emit) begin
                pxl_out <= relu_result;
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool_layer.sv
// Bench for relu_maxpool_layer at D=4: one instance with ReLU bypassed, one with ReLU,
// both fed the same stream and checked against a window-level reference model.
module tb_relu_maxpool_layer;

    localparam int TD = 4;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] pxl_in;
    logic [31:0] pxl_out0, pxl_out1;
    logic        valid_out0, valid_out1;
    logic        frame_done0, frame_done1;

    relu_maxpool_layer #(.D(TD), .DATA_WIDTH(32), .RELU_EN(0)) dut0 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .pxl_out(pxl_out0), .valid_out(valid_out0), .frame_done(frame_done0)
    );

    relu_maxpool_layer #(.D(TD), .DATA_WIDTH(32), .RELU_EN(1)) dut1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
        .pxl_out(pxl_out1), .valid_out(valid_out1), .frame_done(frame_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int fd_cnt = 0;

    typedef struct packed {
        logic [31:0] val;
        logic        fd;
        logic [31:0] due;
    } exp_t;

    typedef struct packed {
        logic [15:0][31:0] pix;
        logic [3:0][31:0]  exp0;
        logic [3:0][31:0]  exp1;
        logic              gaps;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] cap0[$];
    logic [31:0] cap1[$];
    logic [31:0] m_pix [TD][TD];
    int          m_row = 0;
    int          m_col = 0;
    vec_t        tbl [4];

    localparam logic [31:0] POS [16] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
        32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
        32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

    localparam logic [31:0] MIX [16] = '{
        32'hC0000000, 32'h3F000000, 32'h80000000, 32'hBF800000,
        32'h80000000, 32'h3E800000, 32'hC0400000, 32'h80000000,
        32'h3F800000, 32'hC0800000, 32'h40000000, 32'h40400000,
        32'hC0A00000, 32'h3E800000, 32'h41800000, 32'h00000000};

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Signed ordering key: a real-number view of the float; +0 and -0 both map to 0.
    function automatic longint fkey(input logic [31:0] x);
        longint mag;
        mag = longint'(x[30:0]);
        return x[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] mmax(input logic [31:0] a, input logic [31:0] b);
        return (fkey(b) > fkey(a)) ? b : a;
    endfunction

    function automatic logic [31:0] relu_m(input logic [31:0] x);
        return x[31] ? 32'h0 : x;
    endfunction

    task automatic model_accept(input logic [31:0] p);
        exp_t e;
        m_pix[m_row][m_col] = p;
        if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
            e.val = mmax(mmax(mmax(m_pix[m_row-1][m_col-1], m_pix[m_row-1][m_col]),
                              m_pix[m_row][m_col-1]), p);
            e.fd  = (m_row == TD - 1) && (m_col == TD - 1);
            e.due = cyc;
            exp_q.push_back(e);
        end
        m_col++;
        if (m_col == TD) begin
            m_col = 0;
            m_row = (m_row == TD - 1) ? 0 : m_row + 1;
        end
    endtask

    task automatic send(input logic [31:0] p, input int gap);
        repeat (gap) begin
            valid_in = 1'b0;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b1;
        pxl_in   = p;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        model_accept(p);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] rand_pix();
        logic [30:0] mag;
        if ($urandom_range(0, 3) == 0) mag = '0;
        else if ($urandom_range(0, 3) == 0) mag = 31'h3F800000;
        else mag = {8'($urandom_range(100, 150)), 23'($urandom)};
        return {1'($urandom), mag};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_norelu", {valid_out0, frame_done0, pxl_out0}, {1'b1, e.fd, e.val});
                chk("out_relu", {valid_out1, frame_done1, pxl_out1}, {1'b1, e.fd, relu_m(e.val)});
                if (valid_out0) cap0.push_back(pxl_out0);
                if (valid_out1) cap1.push_back(pxl_out1);
                if (frame_done0) fd_cnt++;
            end else if (valid_out0 || valid_out1 || frame_done0 || frame_done1) begin
                chk("spurious_out", {valid_out0, valid_out1, 32'(frame_done0)}, 34'h0);
                if (frame_done0) fd_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd_before;
        for (int i = 0; i < 16; i++) begin
            tbl[0].pix[i] = POS[i];
            tbl[1].pix[i] = POS[i] | 32'h80000000;
            tbl[2].pix[i] = MIX[i];
        end
        tbl[0].exp0 = {POS[15], POS[13], POS[7], POS[5]};
        tbl[0].exp1 = tbl[0].exp0;
        tbl[0].gaps = 1'b0;
        tbl[1].exp0 = {POS[10] | 32'h80000000, POS[8] | 32'h80000000,
                       POS[2] | 32'h80000000, POS[0] | 32'h80000000};
        tbl[1].exp1 = '0;
        tbl[1].gaps = 1'b0;
        tbl[2].exp0 = {32'h41800000, 32'h3F800000, 32'h80000000, 32'h3F000000};
        tbl[2].exp1 = {32'h41800000, 32'h3F800000, 32'h00000000, 32'h3F000000};
        tbl[2].gaps = 1'b0;
        tbl[3] = tbl[0];
        tbl[3].gaps = 1'b1;

        reset    = 1'b1;
        valid_in = 1'b0;
        pxl_in   = 32'h0;
        idle(3);
        chk("reset_dut0", {valid_out0, frame_done0, pxl_out0}, 34'h0);
        chk("reset_dut1", {valid_out1, frame_done1, pxl_out1}, 34'h0);
        reset = 1'b0;
        idle(2);

        for (int t = 0; t < 4; t++) begin
            cap0.delete();
            cap1.delete();
            fd_before = fd_cnt;
            for (int i = 0; i < 16; i++)
                send(tbl[t].pix[i], tbl[t].gaps ? $urandom_range(0, 5) : 0);
            idle(3);
            chk($sformatf("tbl%0d_count", t), 34'(cap0.size() + cap1.size()), 34'd8);
            chk($sformatf("tbl%0d_frame_done", t), 34'(fd_cnt - fd_before), 34'd1);
            for (int k = 0; k < 4; k++) begin
                if (k < cap0.size() && k < cap1.size()) begin
                    chk($sformatf("tbl%0d_norelu_%0d", t, k), {2'b0, cap0[k]}, {2'b0, tbl[t].exp0[k]});
                    chk($sformatf("tbl%0d_relu_%0d", t, k), {2'b0, cap1[k]}, {2'b0, tbl[t].exp1[k]});
                end
            end
        end

        // Two frames back-to-back, no idle cycle at the frame boundary.
        cap0.delete();
        cap1.delete();
        fd_before = fd_cnt;
        for (int i = 0; i < 16; i++) send(tbl[0].pix[i], 0);
        for (int i = 0; i < 16; i++) send(tbl[1].pix[i], 0);
        idle(3);
        chk("b2b_count", 34'(cap0.size()), 34'd8);
        chk("b2b_frame_done", 34'(fd_cnt - fd_before), 34'd2);
        for (int k = 0; k < 4; k++) begin
            if (k + 4 < cap0.size()) begin
                chk($sformatf("b2b_f0_%0d", k), {2'b0, cap0[k]}, {2'b0, tbl[0].exp0[k]});
                chk($sformatf("b2b_f1_%0d", k), {2'b0, cap0[k+4]}, {2'b0, tbl[1].exp0[k]});
            end
        end

        // Random frames, first back-to-back, then with idle gaps.
        fd_before = fd_cnt;
        for (int f = 0; f < 6; f++)
            for (int i = 0; i < 16; i++)
                send(rand_pix(), (f >= 3) ? $urandom_range(0, 5) : 0);
        idle(3);
        chk("rand_frame_done", 34'(fd_cnt - fd_before), 34'd6);

        // Asynchronous reset mid-frame after the 7th pixel.
        for (int i = 0; i < 7; i++) send(POS[i], 0);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_dut0", {valid_out0, frame_done0, pxl_out0}, 34'h0);
        chk("midreset_dut1", {valid_out1, frame_done1, pxl_out1}, 34'h0);
        m_row = 0;
        m_col = 0;
        exp_q.delete();
        idle(2);
        reset = 1'b0;
        cap0.delete();
        cap1.delete();
        for (int i = 0; i < 16; i++) send(POS[i], 0);
        idle(3);
        chk("post_reset_count", 34'(cap0.size()), 34'd4);
        for (int k = 0; k < 4; k++)
            if (k < cap0.size())
                chk($sformatf("post_reset_%0d", k), {2'b0, cap0[k]}, {2'b0, tbl[0].exp0[k]});

        chk("queue_drained", 34'(exp_q.size()), 34'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
